// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath: PC state encoding, instruction field widths
// and the branch-offset helper used by the next-PC logic.
package cpu_pkg;

  typedef enum logic {
    PC_RUN    = 1'b0,
    PC_HALTED = 1'b1
  } pc_state_e;

  // Source of the next PC, in decreasing priority order.
  typedef enum logic [1:0] {
    SelHold,
    SelJump,
    SelBranch,
    SelSeq
  } pc_sel_e;

  localparam int unsigned PC_STEP = 4;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned ADDR_W  = 26;

  // Sign-extended word offset: sext(imm) << 2.
  function automatic logic [31:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{(32 - IMM_W - 2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/cpu_pc_next.sv
// Combinational next-PC selection: branch/jump targets, branch-taken decision and the
// prioritised mux halt > jump > taken branch > sequential.
module cpu_pc_next
  import cpu_pkg::*;
(
  input  logic [31:0]       pc,
  input  logic [31:0]       pc_plus4,
  input  logic              branch_eq,
  input  logic              branch_ne,
  input  logic              branch_ltz,
  input  logic              jump,
  input  logic              halt,
  input  logic              alu_zero,
  input  logic              rs_sign,
  input  logic [IMM_W-1:0]  imm16,
  input  logic [ADDR_W-1:0] addr26,
  output logic [31:0]       branch_target,
  output logic [31:0]       jump_target,
  output logic              branch_taken,
  output logic              redirect,
  output logic [31:0]       next_pc
);

  pc_sel_e sel;

  assign branch_target = pc_plus4 + branch_offset(imm16);
  assign jump_target   = {pc_plus4[31:28], addr26, 2'b00};

  assign branch_taken = (branch_eq & alu_zero)
                      | (branch_ne & ~alu_zero)
                      | (branch_ltz & rs_sign);

  always_comb begin
    sel = SelSeq;
    if (halt) begin
      sel = SelHold;
    end else if (jump) begin
      sel = SelJump;
    end else if (branch_taken) begin
      sel = SelBranch;
    end
  end

  always_comb begin
    next_pc  = pc_plus4;
    redirect = 1'b0;
    unique case (sel)
      SelHold:   next_pc = pc;
      SelJump: begin
        next_pc  = jump_target;
        redirect = 1'b1;
      end
      SelBranch: begin
        next_pc  = branch_target;
        redirect = 1'b1;
      end
      SelSeq:    next_pc = pc_plus4;
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/cpu_pc_unit.sv
// Program-counter stage: PC register, RUN/HALTED state machine and the retired/taken
// debug counters. Next-PC selection lives in cpu_pc_next.
module cpu_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_eq,
  input  logic              branch_ne,
  input  logic              branch_ltz,
  input  logic              jump,
  input  logic              halt,
  input  logic              alu_zero,
  input  logic              rs_sign,
  input  logic [IMM_W-1:0]  imm16,
  input  logic [ADDR_W-1:0] addr26,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              halted,
  output logic [31:0]       retired,
  output logic [31:0]       taken
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("cpu_pc_unit: RESET_PC must be word aligned");
  end

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] taken_q, taken_d;

  logic [31:0] next_pc;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic        redirect;
  logic        advance;

  assign pc_plus4 = pc_q + PC_STEP;

  cpu_pc_next u_pc_next (
    .pc            (pc_q),
    .pc_plus4      (pc_plus4),
    .branch_eq     (branch_eq),
    .branch_ne     (branch_ne),
    .branch_ltz    (branch_ltz),
    .jump          (jump),
    .halt          (halt),
    .alu_zero      (alu_zero),
    .rs_sign       (rs_sign),
    .imm16         (imm16),
    .addr26        (addr26),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .redirect      (redirect),
    .next_pc       (next_pc)
  );

  // An instruction retires only in RUN with no stall; everything else freezes.
  assign advance = (state_q == PC_RUN) && !stall;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    taken_d   = taken_q;
    unique case (state_q)
      PC_RUN: begin
        if (advance) begin
          pc_d      = next_pc;
          retired_d = retired_q + 32'd1;
          if (redirect) begin
            taken_d = taken_q + 32'd1;
          end
          if (halt) begin
            state_d = PC_HALTED;
          end
        end
      end
      PC_HALTED: state_d = PC_HALTED;
      default:   state_d = PC_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PC_RUN;
      pc_q      <= RESET_PC;
      retired_q <= 32'd0;
      taken_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign pc      = pc_q;
  assign halted  = (state_q == PC_HALTED);
  assign retired = retired_q;
  assign taken   = taken_q;

endmodule

// File: tb/tb_cpu_pc_unit.sv
// Directed bench for cpu_pc_unit: a vector table for the main fetch/branch/jump flow and
// short hand-written sequences for halt, stall, wrap-around and reset corner cases.
module tb_cpu_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_eq = 1'b0;
  logic        branch_ne = 1'b0;
  logic        branch_ltz = 1'b0;
  logic        jump = 1'b0;
  logic        halt = 1'b0;
  logic        alu_zero = 1'b0;
  logic        rs_sign = 1'b0;
  logic [15:0] imm16 = 16'h0;
  logic [25:0] addr26 = 26'h0;

  logic [31:0] pc, pc_plus4, retired, taken;
  logic        halted;
  logic [31:0] w_pc, w_pc_plus4, w_retired, w_taken;
  logic        w_halted;
  logic [31:0] j_pc, j_pc_plus4, j_retired, j_taken;
  logic        j_halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .branch_ltz(branch_ltz), .jump(jump), .halt(halt), .alu_zero(alu_zero),
    .rs_sign(rs_sign), .imm16(imm16), .addr26(addr26), .pc(pc), .pc_plus4(pc_plus4),
    .halted(halted), .retired(retired), .taken(taken)
  );

  cpu_pc_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .stall(stall), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .branch_ltz(branch_ltz), .jump(jump), .halt(halt), .alu_zero(alu_zero),
    .rs_sign(rs_sign), .imm16(imm16), .addr26(addr26), .pc(w_pc), .pc_plus4(w_pc_plus4),
    .halted(w_halted), .retired(w_retired), .taken(w_taken)
  );

  cpu_pc_unit #(.RESET_PC(32'h1000_0010)) dut_j (
    .clk(clk), .rst(rst), .stall(stall), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .branch_ltz(branch_ltz), .jump(jump), .halt(halt), .alu_zero(alu_zero),
    .rs_sign(rs_sign), .imm16(imm16), .addr26(addr26), .pc(j_pc), .pc_plus4(j_pc_plus4),
    .halted(j_halted), .retired(j_retired), .taken(j_taken)
  );

  typedef struct {
    logic        stall, beq, bne, bltz, jmp, hlt, zero, sign;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [31:0] e_pc, e_ret, e_tk;
    logic        e_halt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic be, input logic bn, input logic bl,
                              input logic j, input logic h, input logic z, input logic sg,
                              input logic [15:0] im, input logic [25:0] ad,
                              input logic [31:0] epc, input logic [31:0] er,
                              input logic [31:0] et, input logic eh);
    vec_t v;
    v.stall = s;  v.beq = be; v.bne = bn; v.bltz = bl; v.jmp = j; v.hlt = h;
    v.zero = z;   v.sign = sg; v.imm = im; v.addr = ad;
    v.e_pc = epc; v.e_ret = er; v.e_tk = et; v.e_halt = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] epc, input logic [31:0] er,
                             input logic [31:0] et, input logic eh);
    chk({tag, " pc"}, pc, epc);
    chk({tag, " pc_plus4"}, pc_plus4, epc + 32'd4);
    chk({tag, " retired"}, retired, er);
    chk({tag, " taken"}, taken, et);
    chk({tag, " halted"}, {31'd0, halted}, {31'd0, eh});
  endtask

  task automatic clear_in();
    stall = 1'b0; branch_eq = 1'b0; branch_ne = 1'b0; branch_ltz = 1'b0;
    jump = 1'b0; halt = 1'b0; alu_zero = 1'b0; rs_sign = 1'b0;
    imm16 = 16'h0; addr26 = 26'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Main flow from RESET_PC = 0; expected values hand-computed from the next-PC rules.
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 16'h0000, 26'h0,  32'h0000_0004,  1, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 16'h0000, 26'h0,  32'h0000_0008,  2, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 16'h0000, 26'h0,  32'h0000_000C,  3, 0, 0));
    tbl.push_back(mk(0,0,0,0,1,0,0,0, 16'h0000, 26'h8,  32'h0000_0020,  4, 1, 0));
    tbl.push_back(mk(0,1,0,0,0,0,1,0, 16'hFFFE, 26'h0,  32'h0000_001C,  5, 2, 0));
    tbl.push_back(mk(0,0,0,0,1,0,0,0, 16'h0000, 26'h8,  32'h0000_0020,  6, 3, 0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0, 16'hFFFE, 26'h0,  32'h0000_0024,  7, 3, 0));
    tbl.push_back(mk(0,0,0,0,1,0,0,0, 16'h0000, 26'h10, 32'h0000_0040,  8, 4, 0));
    tbl.push_back(mk(0,0,0,1,0,0,0,1, 16'h0003, 26'h0,  32'h0000_0050,  9, 5, 0));
    tbl.push_back(mk(0,0,0,1,0,0,0,0, 16'h0003, 26'h0,  32'h0000_0054, 10, 5, 0));
    tbl.push_back(mk(0,0,1,0,0,0,0,0, 16'h0001, 26'h0,  32'h0000_005C, 11, 6, 0));
    tbl.push_back(mk(0,0,1,0,0,0,1,0, 16'h0001, 26'h0,  32'h0000_0060, 12, 6, 0));
    tbl.push_back(mk(0,0,1,0,1,0,0,0, 16'h0010, 26'h20, 32'h0000_0080, 13, 7, 0));
    tbl.push_back(mk(1,1,0,0,0,0,1,0, 16'h0004, 26'h0,  32'h0000_0080, 13, 7, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 16'h0000, 26'h0,  32'h0000_0084, 14, 7, 0));
    tbl.push_back(mk(0,1,0,1,0,0,1,0, 16'h8000, 26'h0,  32'hFFFE_0088, 15, 8, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 16'h0000, 26'h0,  32'hFFFE_008C, 16, 8, 0));

    tick();
    rst = 1'b0;
    check_state("reset", 32'h0, 0, 0, 1'b0);

    foreach (tbl[i]) begin
      stall = tbl[i].stall; branch_eq = tbl[i].beq; branch_ne = tbl[i].bne;
      branch_ltz = tbl[i].bltz; jump = tbl[i].jmp; halt = tbl[i].hlt;
      alu_zero = tbl[i].zero; rs_sign = tbl[i].sign; imm16 = tbl[i].imm;
      addr26 = tbl[i].addr;
      tick();
      check_state($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_ret, tbl[i].e_tk,
                  tbl[i].e_halt);
    end

    // Reset coinciding with a taken branch wins.
    clear_in();
    rst = 1'b1; branch_eq = 1'b1; alu_zero = 1'b1; imm16 = 16'h0010;
    tick();
    rst = 1'b0;
    clear_in();
    check_state("rst_mid_run", 32'h0, 0, 0, 1'b0);

    // Jump keeps the upper nibble of pc_plus4.
    do_reset();
    chk("jreset pc", j_pc, 32'h1000_0010);
    jump = 1'b1; addr26 = 26'h40;
    tick();
    clear_in();
    chk("jump_upper pc", j_pc, 32'h1000_0100);
    chk("jump_upper taken", j_taken, 32'd1);

    // Halt at 0x30 with retired = 12, combined with jump; then absorbing.
    do_reset();
    for (int k = 0; k < 12; k++) tick();
    check_state("pre_halt", 32'h30, 12, 0, 1'b0);
    halt = 1'b1; jump = 1'b1; addr26 = 26'h100;
    tick();
    check_state("halt", 32'h30, 13, 0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      {stall, branch_eq, branch_ne, branch_ltz, jump, halt, alu_zero, rs_sign} =
        8'($urandom);
      imm16 = 16'($urandom);
      addr26 = 26'($urandom);
      tick();
      check_state($sformatf("halted%0d", k), 32'h30, 13, 0, 1'b1);
    end
    do_reset();
    check_state("rst_from_halt", 32'h0, 0, 0, 1'b0);

    // Stall suppresses a pending halt, which is taken on release.
    tick();
    tick();
    halt = 1'b1; stall = 1'b1;
    tick();
    check_state("stall_halt0", 32'h8, 2, 0, 1'b0);
    tick();
    check_state("stall_halt1", 32'h8, 2, 0, 1'b0);
    stall = 1'b0;
    tick();
    check_state("stall_release", 32'h8, 3, 0, 1'b1);

    // Reset with stall and halt asserted, then PC wrap on the high reset vector.
    rst = 1'b1; stall = 1'b1; halt = 1'b1;
    tick();
    rst = 1'b0;
    clear_in();
    check_state("rst_stall_halt", 32'h0, 0, 0, 1'b0);
    chk("wrap0 pc", w_pc, 32'hFFFF_FFF8);
    tick();
    chk("wrap1 pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap1 pc_plus4", w_pc_plus4, 32'h0000_0000);
    tick();
    chk("wrap2 pc", w_pc, 32'h0000_0000);
    chk("wrap2 retired", w_retired, 32'd2);
    chk("wrap2 halted", {31'd0, w_halted}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_pc_unit.md
# cpu_pc_unit

Program-counter stage of the single-cycle CPU, directly upstream of the opcode decoder. Holds the PC register and selects the next PC from the decoder's branch/jump/halt strobes, the ALU zero flag and the rs sign bit. Runs a two-state RUN/HALTED machine and keeps retired-instruction and taken-branch counters for the debug port. Its `pc` output addresses instruction memory, and the fetched opcode feeds the decoder in the same cycle.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset. Bits [1:0] must be 00; an elaboration check rejects any other value.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold PC and counters for this cycle.
- `branch_eq` in 1: decoder beq strobe.
- `branch_ne` in 1: decoder bne strobe.
- `branch_ltz` in 1: decoder bltz strobe.
- `jump` in 1: decoder j strobe.
- `halt` in 1: decoder halt strobe.
- `alu_zero` in 1: ALU result == 0.
- `rs_sign` in 1: bit 31 of the rs register value.
- `imm16` in 16: instruction[15:0].
- `addr26` in 26: instruction[25:0].
- `pc` out 32: current PC, registered.
- `pc_plus4` out 32: `pc + 4`, combinational. Used as the link/sequential value.
- `halted` out 1: registered; 1 in HALTED.
- `retired` out 32: instructions retired since reset.
- `taken` out 32: branches and jumps taken since reset.

## Operation

States:
- RUN: normal fetch.
- HALTED: absorbing state. Only `rst` leaves it.

Next-PC selection, evaluated in RUN with `stall`=0, highest priority first:
1. `halt`: PC holds. State goes to HALTED.
2. `jump`: PC becomes `{pc_plus4[31:28], addr26, 2'b00}`.
3. Branch taken, PC becomes `pc_plus4 + (sext(imm16) << 2)`. A branch is taken when any of these hold:
   - `branch_eq & alu_zero`
   - `branch_ne & ~alu_zero`
   - `branch_ltz & rs_sign`
4. Otherwise PC becomes `pc_plus4`.

Address arithmetic:
- 32-bit modulo arithmetic. PC wraps from 32'hFFFF_FFFC to 0 silently.
- Branch offset range is -131072..+131068 bytes relative to `pc_plus4`.
- PC[1:0] is always 00.

Counters (RUN, `stall`=0):
- `retired` increments by 1 each cycle, including the halt cycle (the halt instruction counts once).
- `taken` increments on a jump or a taken branch.
- Both counters wrap at 2^32.

Hold conditions:
- `stall`=1 in RUN: PC, state and counters all hold. All strobes are ignored, including `halt`. An instruction that is stalled re-evaluates its strobes on the next unstalled cycle.
- HALTED: all inputs except `rst` are ignored. PC stays at the address of the halt instruction and the counters freeze.
- More than one strobe asserted: resolved purely by the priority order above. This is not an error.

Reset values, applied on a `clk` edge with `rst`=1:
- `pc` = `RESET_PC`
- state = RUN, so `halted` = 0
- `retired` = 0, `taken` = 0

Reset takes effect from any state and on any cycle, including a cycle with `stall` or `halt` asserted. Reset wins over all other inputs.

## Timing

- Single-cycle: strobes sampled at edge N determine `pc` after edge N. No extra latency.
- `halted` rises on the same edge that latches the halt.
- `pc_plus4` is combinational from `pc` only. No combinational path from decoder strobes to `pc`.
- Combinational path strobes → next-PC mux → PC D-input must close in one cycle together with the decode and ALU paths.

## Structure

- Shared package `cpu_pkg` holds:
  - state encoding `PC_RUN` = 1'b0, `PC_HALTED` = 1'b1
  - `PC_STEP` = 4
  - instruction field widths: 16 and 26
- Sub-module `cpu_pc_next`: purely combinational. Computes the branch target, the jump target, branch-taken, and the selected next PC.
- The top level holds the registers and the state machine.

## Test plan

- **Reset and sequential fetch.** Hold `rst` for 1 cycle, then run 3 cycles with no strobes.
  - Expect `pc` = 0 → 4 → 8 → 12, `retired` = 3, `taken` = 0, `halted` = 0.
- **Branch taken and not taken.**
  - At `pc` = 0x20, `branch_eq`=1, `alu_zero`=1, `imm16` = 16'hFFFE: next `pc` = 0x1C, `taken` +1.
  - Same PC with `alu_zero`=0: next `pc` = 0x24, `taken` unchanged.
  - At `pc` = 0x40, `branch_ltz`=1, `rs_sign`=1, `imm16` = 3: next `pc` = 0x50.
- **Jump and priority.**
  - At `pc` = 0x1000_0010, `jump`=1, `addr26` = 26'h40: next `pc` = 0x1000_0100.
  - `jump` and `branch_ne` both asserted: the jump target is taken.
  - `halt` and `jump` both asserted: `pc` holds and `halted` = 1.
- **Halt absorbing.** Halt at `pc` = 0x30 with `retired` = 12.
  - `halted` = 1, `retired` = 13, and `pc` stays 0x30 for 10 cycles while every strobe toggles.
  - `rst` then restores `pc` = `RESET_PC` and `halted` = 0.
- **Stall.** Assert `stall` for 2 cycles while `halt`=1 at `pc` = 0x8.
  - `pc`, `retired`, `taken` and `halted` stay unchanged during the stall.
  - On release, the halt is taken.
- **Wrap-around and reset mid-run.**
  - `RESET_PC` = 32'hFFFF_FFF8: `pc` goes 0xFFFF_FFF8 → 0xFFFF_FFFC → 0x0.
  - Assert `rst` in the same cycle as a taken branch: `pc` = `RESET_PC` and the counters are 0.
